// File: rtl/rob_multi_cdb_pkg.sv
// Shared types and sizing for the multi-CDB reorder buffer.
// Result bus, retire record and the tag compare used by every CDB decoder.
package rob_multi_cdb_pkg;

    localparam int ROB_WIDTH = 4;
    localparam int DEPTH     = 1 << ROB_WIDTH;
    localparam int N_CDB     = 3;
    localparam int REG_WIDTH = 5;
    localparam int N_RD      = 2;
    localparam int DATA_W    = 32;

    typedef logic [ROB_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic              valid;
        tag_t              tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_WIDTH-1:0] arch_num;
        logic [DATA_W-1:0]    data;
    } rob_entry;

    function automatic logic tag_match(input cdb_t c, input tag_t t);
        return c.valid && (c.tag == t);
    endfunction

endpackage

// File: rtl/rob_multi_cdb_if.sv
// Dispatch, CDB, operand-read and retire signals of the reorder buffer.
// master drives dispatch/CDB/read tags/retire-ready; slave is the ROB itself.
interface rob_multi_cdb_if;
    import rob_multi_cdb_pkg::*;

    logic                             flush;
    logic                             alloc_req;
    logic [REG_WIDTH-1:0]             alloc_arch_num;
    logic                             alloc_ready;
    tag_t                             alloc_tag;
    cdb_t [N_CDB-1:0]                 cdb;
    logic [N_RD-1:0][ROB_WIDTH-1:0]   rd_tag;
    logic [N_RD-1:0]                  rd_valid;
    logic [N_RD-1:0][DATA_W-1:0]      rd_data;
    logic                             commit_valid;
    logic                             commit_ready;
    rob_entry                         commit_entry;
    tag_t                             commit_tag;
    logic [ROB_WIDTH:0]               count;

    modport master (
        output flush, alloc_req, alloc_arch_num, cdb, rd_tag, commit_ready,
        input  alloc_ready, alloc_tag, rd_valid, rd_data,
               commit_valid, commit_entry, commit_tag, count
    );

    modport slave (
        input  flush, alloc_req, alloc_arch_num, cdb, rd_tag, commit_ready,
        output alloc_ready, alloc_tag, rd_valid, rd_data,
               commit_valid, commit_entry, commit_tag, count
    );

endinterface

// File: rtl/rob_multi_cdb_cdb_select.sv
// Priority match of one ROB tag against all CDBs; the lowest bus index wins.
module rob_cdb_select
    import rob_multi_cdb_pkg::*;
(
    input  tag_t              i_tag,
    input  cdb_t [N_CDB-1:0]  i_cdb,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    // Walk from the highest index down so the lowest matching bus is the last writer.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if (tag_match(i_cdb[i], i_tag)) begin
                o_hit  = 1'b1;
                o_data = i_cdb[i].data;
            end
        end
    end

endmodule

// File: rtl/rob_multi_cdb.sv
// Reorder buffer: in-order allocate and retire, N_CDB parallel result captures,
// and N_RD tag-indexed operand reads with same-cycle CDB bypass.
module rob_multi_cdb
    import rob_multi_cdb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    rob_multi_cdb_if.slave bus
);

    logic [DEPTH-1:0]     r_busy;
    logic [DEPTH-1:0]     r_valid;
    logic [REG_WIDTH-1:0] r_arch [DEPTH];
    logic [DATA_W-1:0]    r_data [DEPTH];
    tag_t                 r_head;
    tag_t                 r_tail;
    logic [ROB_WIDTH:0]   r_count;

    logic                 w_alloc_ready;
    logic                 w_alloc;
    logic                 w_commit_valid;
    logic                 w_commit;
    logic [DEPTH-1:0]     w_wr_hit;
    logic [DATA_W-1:0]    w_wr_data [DEPTH];
    logic [N_RD-1:0]      w_rd_hit;
    logic [DATA_W-1:0]    w_rd_byp [N_RD];

    assign w_alloc_ready  = (r_count != (ROB_WIDTH + 1)'(DEPTH));
    assign w_alloc        = bus.alloc_req && w_alloc_ready;
    assign w_commit_valid = r_busy[r_head] && r_valid[r_head];
    assign w_commit       = w_commit_valid && bus.commit_ready;

    // One decoder per entry: each entry picks its own write from the buses.
    for (genvar e = 0; e < DEPTH; e++) begin : g_wr
        rob_cdb_select u_wr_sel (
            .i_tag  (ROB_WIDTH'(e)),
            .i_cdb  (bus.cdb),
            .o_hit  (w_wr_hit[e]),
            .o_data (w_wr_data[e])
        );
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        rob_cdb_select u_rd_sel (
            .i_tag  (bus.rd_tag[p]),
            .i_cdb  (bus.cdb),
            .o_hit  (w_rd_hit[p]),
            .o_data (w_rd_byp[p])
        );
    end

    // Commit clears after the CDB set so a late write cannot revive a retired entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_busy  <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wr_hit[e] && r_busy[e]) r_valid[e] <= 1'b1;
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_valid[r_tail] <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; busy/valid qualify every use of it.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (!bus.flush && w_wr_hit[e] && r_busy[e]) r_data[e] <= w_wr_data[e];
        end
        if (!bus.flush && w_alloc) r_arch[r_tail] <= bus.alloc_arch_num;
    end

    always_comb begin
        for (int p = 0; p < N_RD; p++) begin
            if (w_rd_hit[p]) begin
                bus.rd_valid[p] = 1'b1;
                bus.rd_data[p]  = w_rd_byp[p];
            end else begin
                bus.rd_valid[p] = r_busy[bus.rd_tag[p]] && r_valid[bus.rd_tag[p]];
                bus.rd_data[p]  = r_data[bus.rd_tag[p]];
            end
        end
    end

    always_comb begin
        bus.commit_entry          = '0;
        bus.commit_entry.valid    = r_valid[r_head];
        bus.commit_entry.arch_num = r_arch[r_head];
        bus.commit_entry.data     = r_data[r_head];
    end

    assign bus.alloc_ready  = w_alloc_ready;
    assign bus.alloc_tag    = r_tail;
    assign bus.commit_valid = w_commit_valid;
    assign bus.commit_tag   = r_head;
    assign bus.count        = r_count;

    // Two buses writing one tag in a cycle is a producer bug upstream.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_CDB; i++) begin
                for (int j = i + 1; j < N_CDB; j++) begin
                    assert (!(bus.cdb[i].valid && bus.cdb[j].valid &&
                              bus.cdb[i].tag == bus.cdb[j].tag));
                end
            end
        end
    end

endmodule

// File: doc/rob_multi_cdb.md
Name: rob_multi_cdb

Overview:
Parametrised reorder buffer, successor to the single-CDB ROB.
- Allocates one entry per cycle in program order.
- Captures results from N_CDB common data buses in parallel.
- Serves tag-indexed operand reads with same-cycle CDB bypass.
- Retires in order to the register file under a valid/ready handshake; supports a full flush on mispredict.
- Sits between dispatch, the execution units' CDBs and the architectural register file.

Parameters:
ROB_WIDTH, 4, log2 of entry count; DEPTH = 2**ROB_WIDTH
N_CDB, 3, number of CDB write ports
REG_WIDTH, 5, architectural register number width
N_RD, 2, number of operand read ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries
alloc_req  in  1  dispatch requests an entry
alloc_arch_num  in  REG_WIDTH  destination register of the allocated entry
alloc_ready  out  1  an entry is free
alloc_tag  out  ROB_WIDTH  tag granted; equals tail pointer
cdb  in  cdb_t[N_CDB]  result buses (valid, tag, 32-bit data)
rd_tag  in  ROB_WIDTH[N_RD]  operand tags
rd_valid  out  1[N_RD]  operand result available
rd_data  out  32[N_RD]  operand value
commit_valid  out  1  head entry ready to retire
commit_ready  in  1  register file accepts
commit_entry  out  rob_entry  head contents (valid, arch_num, data)
commit_tag  out  ROB_WIDTH  head tag
count  out  ROB_WIDTH+1  occupied entries

Behaviour:
- Reset (rst_n=0, asynchronous):
  - head=tail=0, count=0; all busy and valid bits cleared.
  - Outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, rd_valid=0.
  - Data fields are don't-care.
- Per-entry state: busy (allocated), valid (result written), arch_num, data.
- alloc_ready = (count != DEPTH). This is based on registered state only; a same-cycle commit does not grant an extra slot.
- Allocation fires on alloc_req && alloc_ready:
  - entry[tail] gets busy=1, valid=0, arch_num=alloc_arch_num.
  - tail = tail+1 mod DEPTH.
  - alloc_req while full is ignored with no state change.
- CDB write, for each i with cdb[i].valid:
  - If entry[cdb[i].tag] is busy, set valid=1 and data=cdb[i].data at the clock edge.
  - Writes to non-busy tags are ignored.
  - Two ports with the same tag in one cycle: lowest index wins, and a simulation assertion fires.
- Commit:
  - commit_valid = busy[head] && valid[head], combinational from registered state. A CDB write to head becomes visible the following cycle.
  - commit_valid && commit_ready: clear busy/valid of head, head = head+1 mod DEPTH.
  - commit_entry is held stable while commit_ready=0.
- count: +1 on allocation, -1 on commit, unchanged when both fire in the same cycle.
- Operand read, per port, combinational:
  - If any cdb[i] tag_match(rd_tag): rd_valid=1, rd_data = data of the lowest matching i.
  - Otherwise rd_valid = busy && valid, rd_data = stored data.
  - Reading the head during its commit cycle still returns the stored value.
- Flush:
  - Takes priority over allocation, CDB writes and commit in the same cycle.
  - Next state equals reset state; commit_valid must fall the cycle after flush.
- Wrap-around: pointers are ROB_WIDTH bits and wrap naturally; full vs empty is resolved by count only.

Decomposition:
- my_package already holds cdb_t, rob_entry and tag_match; add parameter N_CDB=3 and N_RD=2 there.
- Sub-module rob_cdb_select: priority match of one tag against N_CDB buses, returning hit and data. Instantiated N_RD times for operand reads and used for the write decode.
- Storage is a flat register array; no SRAM.

Test Plan:
- Reset then 16 allocs (arch 1..16) with no CDB -> tags 0..15, alloc_ready=0 after the 16th, count=16; a 17th alloc_req leaves count=16.
- Alloc tag 0 (arch 3); cdb[2] = {1, 0, 32'hDEADBEEF} -> next cycle commit_valid=1, commit_entry = {1, 3, 32'hDEADBEEF}, commit_tag=0.
- Same cycle: rd_tag[0]=5 with cdb[1] = {1, 5, 32'h1234} and entry 5 not yet valid -> rd_valid[0]=1, rd_data[0]=32'h1234 combinationally.
- Fill to 14, commit 10 with commit_ready toggling every other cycle, allocate 10 more -> tags wrap 14,15,0..7; commits leave in allocation order; count never exceeds 16.
- Full ROB with simultaneous alloc_req and commit -> commit proceeds, allocation refused, count=15 next cycle.
- Mid-run flush with count=7 and CDB active -> next cycle count=0, commit_valid=0, alloc_tag=0; a CDB write to an old tag is ignored afterwards.
